// File: rtl/debug_dump_tx_pkg.sv
// Shared constants and FSM state encoding for the debug dump transmitter.
// CHK/CWAIT states exist only when DEBUG_DUMP_CHKSUM_EN is defined.
package debug_dump_tx_pkg;

  localparam int DUMP_UART_BITS  = 8;
  localparam int DUMP_DATA_BITS  = 256;
  localparam int DUMP_STATE_BITS = 4;

  // Encodings are fixed so the debug unit can decode o_send_state directly.
  typedef enum logic [3:0] {
    DUMP_IDLE  = 4'd0,
    DUMP_LOAD  = 4'd1,
    DUMP_WAIT  = 4'd2,
    DUMP_LAST  = 4'd3,
`ifdef DEBUG_DUMP_CHKSUM_EN
    DUMP_CHK   = 4'd4,
    DUMP_CWAIT = 4'd5,
`endif
    DUMP_DONE  = 4'd6
  } dump_state_t;

endpackage

// File: rtl/debug_dump_tx_shift_reg.sv
// Snapshot holding register: parallel load, UART_BITS-wide right shift,
// low byte always presented for transmission.
module debug_dump_tx_shift_reg
  import debug_dump_tx_pkg::*;
#(
  parameter int UART_BITS = DUMP_UART_BITS,
  parameter int DATA_BITS = DUMP_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 shift,
  input  logic [DATA_BITS-1:0] data,
  output logic [UART_BITS-1:0] low_byte
);

  logic [DATA_BITS-1:0] shreg;

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= data;
    end else if (shift) begin
      shreg <= shreg >> UART_BITS;
    end
  end

  assign low_byte = shreg[UART_BITS-1:0];

endmodule

// File: rtl/debug_dump_tx.sv
// Streams a latched datapath snapshot LSB byte first into uart_tx, one byte per
// tx_start/tx_done handshake. Define DEBUG_DUMP_CHKSUM_EN to append an XOR checksum byte.
module debug_dump_tx
  import debug_dump_tx_pkg::*;
#(
  parameter int UART_BITS  = DUMP_UART_BITS,
  parameter int DATA_BITS  = DUMP_DATA_BITS,
  parameter int STATE_BITS = DUMP_STATE_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [DATA_BITS-1:0]  i_snapshot,
  input  logic                  i_tx_done,
  output logic                  o_tx_start,
  output logic [UART_BITS-1:0]  o_tx_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [STATE_BITS-1:0] o_send_state
);

  localparam int NBYTES = DATA_BITS / UART_BITS;
  localparam int CNT_W  = $clog2(NBYTES + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBYTES - 1);

  if (DATA_BITS % UART_BITS != 0) begin : g_width_check
    $error("debug_dump_tx: DATA_BITS must be a multiple of UART_BITS");
  end

  dump_state_t          state;
  logic [CNT_W-1:0]     cnt;
  logic [UART_BITS-1:0] low_byte;
  logic                 load_sh;
  logic                 shift_sh;
`ifdef DEBUG_DUMP_CHKSUM_EN
  logic [UART_BITS-1:0] chk;
`endif

  assign load_sh  = (state == DUMP_IDLE) && i_start;
  assign shift_sh = (state == DUMP_WAIT) && i_tx_done;

  debug_dump_tx_shift_reg #(
    .UART_BITS (UART_BITS),
    .DATA_BITS (DATA_BITS)
  ) u_shreg (
    .clk      (clk),
    .rst      (rst),
    .load     (load_sh),
    .shift    (shift_sh),
    .data     (i_snapshot),
    .low_byte (low_byte)
  );

  // o_done is raised on entry to DONE so a start coinciding with it is still refused.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= DUMP_IDLE;
      cnt        <= '0;
      o_tx_start <= 1'b0;
      o_tx_data  <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
`ifdef DEBUG_DUMP_CHKSUM_EN
      chk        <= '0;
`endif
    end else begin
      o_tx_start <= 1'b0;
      o_done     <= 1'b0;
      case (state)
        DUMP_IDLE: begin
          if (i_start) begin
            cnt    <= '0;
            o_busy <= 1'b1;
`ifdef DEBUG_DUMP_CHKSUM_EN
            chk    <= '0;
`endif
            state  <= DUMP_LOAD;
          end
        end
        DUMP_LOAD: begin
          o_tx_data  <= low_byte;
          o_tx_start <= 1'b1;
`ifdef DEBUG_DUMP_CHKSUM_EN
          chk        <= chk ^ low_byte;
`endif
          state      <= DUMP_WAIT;
        end
        DUMP_WAIT: begin
          if (i_tx_done) begin
            if (cnt == LAST_CNT) begin
              state <= DUMP_LAST;
            end else begin
              cnt   <= cnt + CNT_W'(1);
              state <= DUMP_LOAD;
            end
          end
        end
        DUMP_LAST: begin
`ifdef DEBUG_DUMP_CHKSUM_EN
          state  <= DUMP_CHK;
`else
          o_done <= 1'b1;
          state  <= DUMP_DONE;
`endif
        end
`ifdef DEBUG_DUMP_CHKSUM_EN
        DUMP_CHK: begin
          o_tx_data  <= chk;
          o_tx_start <= 1'b1;
          state      <= DUMP_CWAIT;
        end
        DUMP_CWAIT: begin
          if (i_tx_done) begin
            o_done <= 1'b1;
            state  <= DUMP_DONE;
          end
        end
`endif
        DUMP_DONE: begin
          o_busy <= 1'b0;
          state  <= DUMP_IDLE;
        end
        default: state <= DUMP_IDLE;
      endcase
    end
  end

  assign o_send_state = STATE_BITS'(state);

endmodule

// File: tb/tb_debug_dump_tx.sv
// Directed bench for debug_dump_tx (DATA_BITS=32) with a uart_tx model that
// answers each o_tx_start with an i_tx_done pulse after done_delay cycles.
module tb_debug_dump_tx;

`ifdef DEBUG_DUMP_CHKSUM_EN
  localparam int CHK_BYTES = 1;
`else
  localparam int CHK_BYTES = 0;
`endif
  localparam int NB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_start = 1'b0;
  logic [31:0] i_snapshot = '0;
  logic        i_tx_done;
  logic        o_tx_start;
  logic [7:0]  o_tx_data;
  logic        o_busy;
  logic        o_done;
  logic [3:0]  o_send_state;

  logic        model_done = 1'b0;
  logic        manual_done = 1'b0;
  int          done_delay = 10;
  int          cd = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  logic [7:0]  log_b[$];
  int          log_t[$];
  int          checks = 0;
  int          failures = 0;

  assign i_tx_done = model_done | manual_done;

  debug_dump_tx #(
    .UART_BITS  (8),
    .DATA_BITS  (32),
    .STATE_BITS (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (i_start),
    .i_snapshot   (i_snapshot),
    .i_tx_done    (i_tx_done),
    .o_tx_start   (o_tx_start),
    .o_tx_data    (o_tx_data),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_send_state (o_send_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // uart_tx stand-in: logs every byte handed over and answers with a done pulse.
  always @(negedge clk) begin
    model_done = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) model_done = 1'b1;
    end
    if (o_tx_start) begin
      log_b.push_back(o_tx_data);
      log_t.push_back(cyc);
      cd = done_delay;
    end
    if (o_done) done_cnt++;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] snap);
    @(posedge clk); #1;
    i_snapshot = snap;
    i_start    = 1'b1;
    @(posedge clk); #1;
    i_start    = 1'b0;
  endtask

  task automatic clear_log();
    log_b.delete();
    log_t.delete();
    done_cnt = 0;
  endtask

  task automatic wait_log(input int n, input int bound);
    bit got = 0;
    for (int k = 0; k < bound && !got; k++) begin
      @(posedge clk); #1;
      if (log_b.size() >= n) got = 1;
    end
    checkOutput("wait_log", 64'(got), 64'd1);
  endtask

  // Returns sampled at the negedge where o_done is high; the FSM is then in DONE.
  task automatic wait_done(input int bound);
    bit got = 0;
    for (int k = 0; k < bound && !got; k++) begin
      @(negedge clk);
      if (o_done) got = 1;
    end
    checkOutput("done_seen", 64'(got), 64'd1);
    checkOutput("done_state", 64'(o_send_state), 64'd6);
    @(posedge clk); #1;
    checkOutput("busy_after_done", 64'(o_busy), 64'd0);
    checkOutput("idle_after_done", 64'(o_send_state), 64'd0);
  endtask

  task automatic check_dump(input string tag, input logic [31:0] snap, input int gap);
    logic [7:0] exp_b;
    logic [7:0] chk = '0;
    repeat (15) @(posedge clk);
    #1;
    checkOutput({tag, "_count"}, 64'(log_b.size()), 64'(NB + CHK_BYTES));
    checkOutput({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
    for (int i = 0; i < NB && i < log_b.size(); i++) begin
      exp_b = snap[8*i +: 8];
      chk   = chk ^ exp_b;
      checkOutput($sformatf("%s_byte%0d", tag, i), 64'(log_b[i]), 64'(exp_b));
      if (i > 0) checkOutput($sformatf("%s_gap%0d", tag, i), 64'(log_t[i] - log_t[i-1]), 64'(gap));
    end
    if (CHK_BYTES == 1 && log_b.size() > NB)
      checkOutput({tag, "_chk"}, 64'(log_b[NB]), 64'(chk));
  endtask

  initial begin
    $display("[TB] start, checksum bytes=%0d", CHK_BYTES);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_tx_start", 64'(o_tx_start), 64'd0);
    checkOutput("rst_tx_data", 64'(o_tx_data), 64'd0);
    checkOutput("rst_busy", 64'(o_busy), 64'd0);
    checkOutput("rst_done", 64'(o_done), 64'd0);
    checkOutput("rst_state", 64'(o_send_state), 64'd0);
    rst = 1'b0;

    // Basic dump plus first-byte latency: LOAD right after start, o_tx_start one cycle later.
    clear_log();
    applyStimulus(32'h04030201);
    checkOutput("t1_busy", 64'(o_busy), 64'd1);
    checkOutput("t1_load", 64'(o_send_state), 64'd1);
    checkOutput("t1_no_start_yet", 64'(o_tx_start), 64'd0);
    @(posedge clk); #1;
    checkOutput("t1_first_start", 64'(o_tx_start), 64'd1);
    checkOutput("t1_first_data", 64'(o_tx_data), 64'h01);
    checkOutput("t1_wait", 64'(o_send_state), 64'd2);
    @(posedge clk); #1;
    checkOutput("t1_start_pulse", 64'(o_tx_start), 64'd0);
    checkOutput("t1_data_held", 64'(o_tx_data), 64'h01);
    wait_done(300);
    check_dump("t1", 32'h04030201, 12);

    // Start while busy, then snapshot change after latch: dump must be untouched.
    clear_log();
    applyStimulus(32'h04030201);
    wait_log(1, 50);
    applyStimulus(32'hFFFFFFFF);
    i_snapshot = 32'h0;
    checkOutput("t3_still_busy", 64'(o_busy), 64'd1);
    wait_done(300);
    check_dump("t3", 32'h04030201, 12);

    // Reset in WAIT of byte 2; the late i_tx_done must be ignored.
    clear_log();
    applyStimulus(32'h04030201);
    wait_log(2, 50);
    checkOutput("t5_in_wait", 64'(o_send_state), 64'd2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("t5_tx_start", 64'(o_tx_start), 64'd0);
    checkOutput("t5_tx_data", 64'(o_tx_data), 64'd0);
    checkOutput("t5_busy", 64'(o_busy), 64'd0);
    checkOutput("t5_state", 64'(o_send_state), 64'd0);
    repeat (15) @(posedge clk);
    #1;
    checkOutput("t5_no_more_bytes", 64'(log_b.size()), 64'd2);
    checkOutput("t5_idle_kept", 64'(o_send_state), 64'd0);
    clear_log();
    applyStimulus(32'hAABBCCDD);
    wait_done(300);
    check_dump("t5", 32'hAABBCCDD, 12);

    // Spurious done in IDLE, then the tightest legal handshake.
    clear_log();
    manual_done = 1'b1;
    @(posedge clk); #1;
    manual_done = 1'b0;
    checkOutput("t6_spur_state", 64'(o_send_state), 64'd0);
    checkOutput("t6_spur_busy", 64'(o_busy), 64'd0);
    checkOutput("t6_spur_start", 64'(o_tx_start), 64'd0);
    done_delay = 1;
    applyStimulus(32'h04030201);
    wait_done(100);
    check_dump("t6", 32'h04030201, 3);
    done_delay = 10;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
